mips_run_controller: RTL and testbench

Synthesizable program-load and run controller for the single-cycle MIPS core. It packs a byte stream into 32-bit words and writes them into instruction memory, then holds the core in reset for a programmable time. It runs the core until a halt instruction or a cycle limit is reached, then freezes it for inspection. It replaces the fixed load/reset/run-N-cycles sequence used in simulation with a parametrised hardware sequencer usable on silicon and in benches.

---
 rtl/mips_run_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_mips_run_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_controller.sv
// mips_run_controller
// Loads a program byte stream into instruction memory (four bytes packed per
// word, first byte in bits 31:24), then sequences the core through a
// programmable reset phase and a run phase. The run ends on a halt
// instruction or a cycle limit, and the core is then frozen for inspection.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_valid/ready/data/last byte-stream handshake for program loading
//   clr, start, cycle_limit   control: clear status, begin run, run limit
//   imem_we/addr/wdata        instruction-memory write port
//   cpu_rst, cpu_en, cpu_instr core reset, clock enable, executing instruction
//   busy, done, halted, ovf   status flags
//   words_loaded, cycles_run  status counters
module mips_run_controller #(
    parameter int          ADDR_W     = 8,
    parameter int          CYCLE_W    = 16,
    parameter int          MAX_CYCLES = 200,
    parameter int          RST_CYCLES = 2,
    parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [7:0]         load_data,
    input  logic               load_last,
    input  logic               clr,
    input  logic               start,
    input  logic [CYCLE_W-1:0] cycle_limit,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_rst,
    output logic               cpu_en,
    input  logic [31:0]        cpu_instr,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic               ovf,
    output logic [ADDR_W:0]    words_loaded,
    output logic [CYCLE_W-1:0] cycles_run
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RESET_CPU = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [23:0]        pack_r, pack_s;
    logic [1:0]         phase_r, phase_s;
    logic [CYCLE_W-1:0] limit_r, limit_s;
    logic [RC_W-1:0]    rc_cnt_r, rc_cnt_s;

    logic               load_ready_s, imem_we_s, cpu_rst_s, cpu_en_s;
    logic               busy_s, done_s, halted_s, ovf_s;
    logic [ADDR_W-1:0]  imem_addr_s;
    logic [31:0]        imem_wdata_s, word_s;
    logic [ADDR_W:0]    words_loaded_s;
    logic [CYCLE_W-1:0] cycles_run_s, eff_limit_s;
    logic [CYCLE_W:0]   run_next_s;
    logic               accept_s, byte_go_s;

    // Handshake, limit selection and next cycle count (one bit wider so the
    // limit compare is exact even at the top of the range).
    assign accept_s    = load_valid & load_ready;
    assign eff_limit_s = (cycle_limit == {CYCLE_W{1'b0}}) ? CYCLE_W'(MAX_CYCLES) : cycle_limit;
    assign run_next_s  = {1'b0, cycles_run} + (CYCLE_W + 1)'(1);

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_s        = state_r;
        pack_s         = pack_r;
        phase_s        = phase_r;
        limit_s        = limit_r;
        rc_cnt_s       = rc_cnt_r;
        imem_we_s      = 1'b0;
        imem_addr_s    = imem_addr;
        imem_wdata_s   = imem_wdata;
        halted_s       = halted;
        ovf_s          = ovf;
        words_loaded_s = words_loaded;
        cycles_run_s   = cycles_run;
        word_s         = 32'h0000_0000;
        byte_go_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (clr) begin
                    words_loaded_s = {(ADDR_W + 1){1'b0}};
                    ovf_s          = 1'b0;
                    halted_s       = 1'b0;
                    cycles_run_s   = {CYCLE_W{1'b0}};
                    phase_s        = 2'd0;
                end else if (accept_s) begin
                    byte_go_s = 1'b1;
                end else if (start) begin
                    state_s      = ST_RESET_CPU;
                    rc_cnt_s     = {RC_W{1'b0}};
                    cycles_run_s = {CYCLE_W{1'b0}};
                    halted_s     = 1'b0;
                    limit_s      = eff_limit_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    byte_go_s = 1'b1;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RESET_CPU: begin
                if (rc_cnt_r == RC_W'(RST_CYCLES - 1)) begin
                    state_s = ST_RUN;
                end else begin
                    rc_cnt_s = rc_cnt_r + RC_W'(1);
                end
            end
            ST_RUN: begin
                cycles_run_s = (&cycles_run) ? cycles_run : run_next_s[CYCLE_W-1:0];
                // Halt takes priority over the limit when both hit together.
                if (cpu_instr == HALT_INSTR) begin
                    state_s  = ST_DONE;
                    halted_s = 1'b1;
                end else if (run_next_s == {1'b0, limit_r}) begin
                    state_s  = ST_DONE;
                    halted_s = 1'b0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clr) begin
                    state_s        = ST_IDLE;
                    words_loaded_s = {(ADDR_W + 1){1'b0}};
                    ovf_s          = 1'b0;
                    halted_s       = 1'b0;
                    cycles_run_s   = {CYCLE_W{1'b0}};
                end else if (start) begin
                    state_s      = ST_RESET_CPU;
                    rc_cnt_s     = {RC_W{1'b0}};
                    cycles_run_s = {CYCLE_W{1'b0}};
                    halted_s     = 1'b0;
                    limit_s      = eff_limit_s;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Byte packing. Once the pointer reaches depth, bytes are swallowed
        // and flagged; the pointer never wraps back onto loaded code.
        if (byte_go_s) begin
            if (words_loaded[ADDR_W]) begin
                ovf_s = 1'b1;
            end else begin
                case (phase_r)
                    2'd0:    word_s = {load_data, 24'h00_0000};
                    2'd1:    word_s = {pack_r[7:0], load_data, 16'h0000};
                    2'd2:    word_s = {pack_r[15:0], load_data, 8'h00};
                    2'd3:    word_s = {pack_r, load_data};
                    default: word_s = 32'h0000_0000;
                endcase
                pack_s = {pack_r[15:0], load_data};
                if ((phase_r == 2'd3) || load_last) begin
                    imem_we_s      = 1'b1;
                    imem_addr_s    = words_loaded[ADDR_W-1:0];
                    imem_wdata_s   = word_s;
                    words_loaded_s = words_loaded + (ADDR_W + 1)'(1);
                    phase_s        = 2'd0;
                end else begin
                    phase_s = phase_r + 2'd1;
                end
            end
            if (load_last) begin
                state_s = ST_IDLE;
                phase_s = 2'd0;
            end else begin
                state_s = ST_LOAD;
            end
        end else begin
            pack_s = pack_r;
        end

        // Status outputs follow the state being entered so they are registered.
        load_ready_s = (state_s == ST_IDLE) || (state_s == ST_LOAD);
        busy_s       = (state_s == ST_LOAD) || (state_s == ST_RESET_CPU) || (state_s == ST_RUN);
        done_s       = (state_s == ST_DONE);
        cpu_en_s     = (state_s == ST_RUN);
        cpu_rst_s    = !((state_s == ST_RUN) || (state_s == ST_DONE));
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pack_r       <= 24'h00_0000;
            phase_r      <= 2'd0;
            limit_r      <= {CYCLE_W{1'b0}};
            rc_cnt_r     <= {RC_W{1'b0}};
            load_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= {ADDR_W{1'b0}};
            imem_wdata   <= 32'h0000_0000;
            cpu_rst      <= 1'b1;
            cpu_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            halted       <= 1'b0;
            ovf          <= 1'b0;
            words_loaded <= {(ADDR_W + 1){1'b0}};
            cycles_run   <= {CYCLE_W{1'b0}};
        end else begin
            state_r      <= state_s;
            pack_r       <= pack_s;
            phase_r      <= phase_s;
            limit_r      <= limit_s;
            rc_cnt_r     <= rc_cnt_s;
            load_ready   <= load_ready_s;
            imem_we      <= imem_we_s;
            imem_addr    <= imem_addr_s;
            imem_wdata   <= imem_wdata_s;
            cpu_rst      <= cpu_rst_s;
            cpu_en       <= cpu_en_s;
            busy         <= busy_s;
            done         <= done_s;
            halted       <= halted_s;
            ovf          <= ovf_s;
            words_loaded <= words_loaded_s;
            cycles_run   <= cycles_run_s;
        end
    end

endmodule

// File: tb/tb_mips_run_controller.sv
// Self-checking bench for mips_run_controller (ADDR_W = 2 so the full-memory
// path is reachable). Loads are predicted by chunking each byte program into
// padded words against a capacity counter; runs are predicted from the limit
// and halt position alone.
module tb_mips_run_controller;

    localparam int          ADDR_W     = 2;
    localparam int          CYCLE_W    = 16;
    localparam int          MAX_CYCLES = 200;
    localparam int          RST_CYCLES = 2;
    localparam int          DEPTH      = 1 << ADDR_W;
    localparam logic [31:0] HALT       = 32'h0000_000C;

    logic               clk = 1'b0;
    logic               rst, load_valid, load_ready, load_last, clr, start;
    logic [7:0]         load_data;
    logic [CYCLE_W-1:0] cycle_limit;
    logic               imem_we, cpu_rst, cpu_en, busy, done, halted, ovf;
    logic [ADDR_W-1:0]  imem_addr;
    logic [31:0]        imem_wdata, cpu_instr;
    logic [ADDR_W:0]    words_loaded;
    logic [CYCLE_W-1:0] cycles_run;

    int n_tests = 0;
    int n_fail  = 0;

    // reference-model state
    int          wl_m;
    bit          ovf_m;
    bit          in_done;
    logic [7:0]  prog [64];
    logic [63:0] exp_q [$];
    logic [63:0] cap_q [$];

    always #5 clk = ~clk;

    mips_run_controller #(
        .ADDR_W(ADDR_W), .CYCLE_W(CYCLE_W), .MAX_CYCLES(MAX_CYCLES),
        .RST_CYCLES(RST_CYCLES), .HALT_INSTR(HALT)
    ) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last), .clr(clr), .start(start), .cycle_limit(cycle_limit),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cpu_instr(cpu_instr),
        .busy(busy), .done(done), .halted(halted), .ovf(ovf),
        .words_loaded(words_loaded), .cycles_run(cycles_run)
    );

    // capture every memory write as {addr, data}
    always @(negedge clk) begin
        if (imem_we === 1'b1) cap_q.push_back({{(32 - ADDR_W){1'b0}}, imem_addr, imem_wdata});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nonhalt();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = 32'h0000_0000;
        return v;
    endfunction

    task automatic do_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        wl_m = 0; ovf_m = 1'b0; in_done = 1'b0;
        check_eq("clr_words", words_loaded, 0);
        check_eq("clr_ovf", ovf, 0);
        check_eq("clr_cycles", cycles_run, 0);
        check_eq("clr_ready", load_ready, 1);
    endtask

    task automatic load_bytes(input int n);
        int i, guard, nw;
        logic [31:0] w;
        exp_q.delete();
        cap_q.delete();
        for (int k = 0; k * 4 < n; k++) begin
            w = 32'h0000_0000;
            for (int b = 0; b < 4; b++)
                if (k * 4 + b < n) w[31 - 8 * b -: 8] = prog[k * 4 + b];
            if (wl_m < DEPTH) begin
                exp_q.push_back({32'(wl_m), w});
                wl_m++;
            end else begin
                ovf_m = 1'b1;
            end
        end
        i = 0; guard = 0;
        while (i < n && guard < 400) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
            end else begin
                load_valid = 1'b1;
                load_data  = prog[i];
                load_last  = (i == n - 1);
                if (load_ready) i++;
            end
        end
        check_eq("load_timeout", 64'(i), 64'(n));
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
        @(negedge clk);
        nw = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        check_eq("nwrites", 64'(cap_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < nw; k++) check_eq("write", cap_q[k], exp_q[k]);
        check_eq("words_loaded", words_loaded, 64'(wl_m));
        check_eq("ovf", ovf, 64'(ovf_m));
        check_eq("load_idle_busy", busy, 0);
        check_eq("load_idle_ready", load_ready, 1);
    endtask

    task automatic run_prog(input int limit, input int halt, input int rst_at);
        int lim_e, k, rc, en, guard, bad;
        bit h, fin;
        lim_e = (limit == 0) ? MAX_CYCLES : limit;
        if (halt != 0 && halt <= lim_e) begin k = halt; h = 1'b1; end
        else begin k = lim_e; h = 1'b0; end
        @(negedge clk); start = 1'b1; cycle_limit = CYCLE_W'(limit);
        @(negedge clk); start = 1'b0;
        rc = 0; en = 0; guard = 0; bad = 0; fin = 1'b0;
        while (!fin && guard < 3000) begin
            guard++;
            if (cpu_en) begin
                en++;
                if (cpu_rst) bad++;
                if (rst_at != 0 && en == rst_at) begin rst = 1'b1; fin = 1'b1; end
                cpu_instr = (en == halt) ? HALT : nonhalt();
            end else if (en > 0) begin
                fin = 1'b1;
            end else if (cpu_rst && busy) begin
                rc++;
            end
            if (!fin) @(negedge clk);
        end
        check_eq("run_timeout", fin, 1);
        check_eq("rst_cycles", 64'(rc), 64'(RST_CYCLES));
        check_eq("cpu_rst_in_run", 64'(bad), 0);
        cpu_instr = nonhalt();
        if (rst_at != 0) begin
            @(negedge clk);
            rst = 1'b0;
            check_eq("mid_rst_cpu_rst", cpu_rst, 1);
            check_eq("mid_rst_cpu_en", cpu_en, 0);
            check_eq("mid_rst_busy", busy, 0);
            check_eq("mid_rst_done", done, 0);
            check_eq("mid_rst_words", words_loaded, 0);
            check_eq("mid_rst_cycles", cycles_run, 0);
            check_eq("mid_rst_halted", halted, 0);
            check_eq("mid_rst_ready", load_ready, 0);
            wl_m = 0; ovf_m = 1'b0; in_done = 1'b0;
        end else begin
            check_eq("en_cycles", 64'(en), 64'(k));
            check_eq("done", done, 1);
            check_eq("halted", halted, 64'(h));
            check_eq("cycles_run", cycles_run, 64'(k));
            check_eq("done_cpu_rst", cpu_rst, 0);
            check_eq("done_busy", busy, 0);
            check_eq("done_ready", load_ready, 0);
            check_eq("run_words_kept", words_loaded, 64'(wl_m));
            in_done = 1'b1;
        end
    endtask

    initial begin
        int n, lim, hc;
        rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        clr = 1'b0; start = 1'b0; cycle_limit = '0; cpu_instr = 32'h0000_0000;
        wl_m = 0; ovf_m = 1'b0; in_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", load_ready, 0);
        check_eq("rst_we", imem_we, 0);
        check_eq("rst_addr", imem_addr, 0);
        check_eq("rst_wdata", imem_wdata, 0);
        check_eq("rst_cpu_rst", cpu_rst, 1);
        check_eq("rst_cpu_en", cpu_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_status", {halted, ovf}, 0);
        check_eq("rst_words", words_loaded, 0);
        check_eq("rst_cycles", cycles_run, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", load_ready, 1);

        // 8 bytes 01..08
        for (int i = 0; i < 8; i++) prog[i] = 8'(i + 1);
        load_bytes(8);
        // partial word after clr
        do_clr();
        prog[0] = 8'hAA; prog[1] = 8'hBB; prog[2] = 8'hCC; prog[3] = 8'hDD; prog[4] = 8'hEE;
        load_bytes(5);
        // overflow: 20 bytes into 4 words
        do_clr();
        for (int i = 0; i < 20; i++) prog[i] = 8'(8'h30 + i);
        load_bytes(20);

        run_prog(0, 0, 0);
        run_prog(10, 10, 0);
        run_prog(10, 4, 0);
        do_clr();

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                if (in_done || $urandom_range(0, 3) == 0) do_clr();
                n = $urandom_range(1, 20);
                for (int i = 0; i < n; i++) prog[i] = 8'($urandom);
                load_bytes(n);
            end else begin
                lim = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
                hc  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 45);
                run_prog(lim, hc, 0);
            end
        end

        run_prog(20, 0, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
